// File: rtl/calc_datapath_unit.sv
// rtl/calc_datapath_unit.sv - operand/result datapath for the calculator controller
// ADD/SUB complete in one cycle; MUL/DIV iterate one bit per clock.
module calc_datapath_unit #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear_n,
  input  logic           load_a_n,
  input  logic           load_b_n,
  input  logic           load_r_n,
  input  logic           load_ou_n,
  input  logic           iuau,
  input  logic [W-1:0]   sw,
  input  logic [1:0]     op,
  output logic [W-1:0]   a_q,
  output logic [W-1:0]   b_q,
  output logic [2*W-1:0] result,
  output logic [2*W-1:0] disp,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int ITERS = W;
  localparam int CW    = $clog2(ITERS + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             load_r_hist_q;
  logic [W-1:0]     opa_q, opb_q;
  logic [1:0]       opc_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   prod_q, mcand_q;
  logic [W-1:0]     mplier_q;
  logic [W:0]       rem_q;
  logic [W-1:0]     quo_q;

  logic             start;
  logic             calc_done;
  logic             set_err;
  logic [2*W-1:0]   final_res;
  logic [W:0]       sum;
  logic [W-1:0]     diff;
  logic [W:0]       rem_shift;
  logic [W:0]       trial;

  assign start     = !load_r_n && load_r_hist_q && (state_q == S_IDLE);
  assign sum       = {1'b0, opa_q} + {1'b0, opb_q};
  assign diff      = opa_q - opb_q;
  assign rem_shift = {rem_q[W-1:0], quo_q[W-1]};
  // Partial remainder is always below the divisor, so bit W flags a negative trial.
  assign trial     = rem_shift - {1'b0, opb_q};

  always_comb begin
    calc_done = 1'b0;
    set_err   = 1'b0;
    final_res = '0;
    case (opc_q)
      OP_ADD: begin
        calc_done = 1'b1;
        final_res = {{(W-1){1'b0}}, sum};
      end
      OP_SUB: begin
        calc_done = 1'b1;
        final_res = {{W{1'b0}}, diff};
        set_err   = (opa_q < opb_q);
      end
      OP_MUL: begin
        calc_done = (cnt_q == CW'(ITERS));
        final_res = prod_q;
      end
      default: begin
        if (opb_q == '0) begin
          calc_done = 1'b1;
          final_res = '1;
          set_err   = 1'b1;
        end else begin
          calc_done = (cnt_q == CW'(ITERS));
          final_res = {rem_q[W-1:0], quo_q};
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || !clear_n) state_q <= S_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (calc_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CALC);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_r_hist_q <= 1'b1;
      a_q <= '0; b_q <= '0; result <= '0; disp <= '0; err <= 1'b0;
      opa_q <= '0; opb_q <= '0; opc_q <= '0; cnt_q <= '0;
      prod_q <= '0; mcand_q <= '0; mplier_q <= '0; rem_q <= '0; quo_q <= '0;
    end else begin
      load_r_hist_q <= load_r_n;
      if (!clear_n) begin
        a_q <= '0; b_q <= '0; result <= '0; disp <= '0; err <= 1'b0;
        opa_q <= '0; opb_q <= '0; opc_q <= '0; cnt_q <= '0;
        prod_q <= '0; mcand_q <= '0; mplier_q <= '0; rem_q <= '0; quo_q <= '0;
      end else begin
        if (start) begin
          opa_q    <= a_q;
          opb_q    <= b_q;
          opc_q    <= op;
          cnt_q    <= '0;
          prod_q   <= '0;
          mcand_q  <= {{W{1'b0}}, a_q};
          mplier_q <= b_q;
          rem_q    <= '0;
          quo_q    <= a_q;
        end else begin
          if (!load_a_n) a_q <= sw;
          if (!load_b_n) b_q <= sw;
        end
        if (state_q == S_CALC) begin
          if (calc_done) begin
            result <= final_res;
            if (set_err) err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (opc_q == OP_MUL) begin
              if (mplier_q[0]) prod_q <= prod_q + mcand_q;
              mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
              mplier_q <= {1'b0, mplier_q[W-1:1]};
            end else begin
              rem_q <= trial[W] ? rem_shift : trial;
              quo_q <= {quo_q[W-2:0], ~trial[W]};
            end
          end
        end
        disp <= iuau ? result : (!load_ou_n ? {{W{1'b0}}, sw} : {{W{1'b0}}, a_q});
      end
    end
  end
endmodule
